bcd_updown_counter_n: RTL and testbench
=======================================

BCD_UPDOWN_COUNTER_N -- requirements
Module: bcd_updown_counter_n

Interface
REQ-001 Parameter DIGITS, default 4, is the number of BCD digits held and displayed (1..8).
REQ-002 Parameter W, default 14, is the width of the binary parallel-load input (W >= 4).
REQ-003 Port in_clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port in_sel  input  2  mode: 00 hold, 01 count down, 10 count up, 11 load.
REQ-006 Port in_en  input  1  count enable; qualifies modes 01/10 only.
REQ-007 Port in_p  input  W  unsigned binary load value.
REQ-008 Port ou_bcd  output  4*DIGITS  current count; digit 0 (units) in [3:0].
REQ-009 Port ou_seg  output  7*DIGITS  active-low 7-segment patterns; digit i in [7i+6:7i], bit order {g,f,e,d,c,b,a}.
REQ-010 Port ou_busy  output  1  binary-to-BCD load conversion in progress.
REQ-011 Port ou_tc  output  1  terminal count: the next counting edge wraps.

Function
REQ-012 The block SHALL have two states: IDLE and CONV.
REQ-013 In IDLE, in_sel=11 sampled at edge k SHALL capture in_p, enter CONV, and set ou_busy=1 after edge k.
REQ-014 CONV SHALL perform one shift-add-3 (double-dabble) step per cycle for W cycles, with no combinational W-bit divide.
REQ-015 At edge k+W, the converted value SHALL be written to ou_bcd, ou_busy SHALL drop to 0, and the state SHALL return to IDLE; busy is high for exactly W cycles.
REQ-016 If the captured in_p exceeds 10^DIGITS-1, the load result SHALL saturate to all digits 9, with the same W-cycle latency.
REQ-017 During CONV, in_sel and in_en SHALL be ignored and ou_bcd SHALL hold its pre-load value.
REQ-018 In IDLE with in_sel=10 and in_en=1, the count SHALL increment by one in BCD, with carry rippling across digits in a single cycle.
REQ-019 In IDLE with in_sel=01 and in_en=1, the count SHALL decrement by one in BCD, with borrow rippling in a single cycle.
REQ-020 Up-count from all 9s SHALL wrap to all 0s, and down-count from all 0s SHALL wrap to all 9s.
REQ-021 in_sel=00, or in_en=0 with in_sel of 01/10, SHALL hold the count.
REQ-022 ou_tc SHALL be combinational and equal 1 iff IDLE & in_en & ((in_sel=10 & count all 9s) | (in_sel=01 & count all 0s)).
REQ-023 ou_seg SHALL be a combinational decode of ou_bcd (0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000); digit codes 10-15 SHALL display blank (1111111).
REQ-024 Every digit of ou_bcd SHALL remain in 0..9 at all times after reset.

Reset
REQ-025 rst=1 at an edge SHALL force the state to IDLE, ou_bcd=0, ou_busy=0, and clear conversion registers; every ou_seg digit then SHALL read 1000000 and ou_tc SHALL follow REQ-022.
REQ-026 rst SHALL have priority over every in_sel/in_en combination, including mid-CONV; an aborted conversion SHALL never write ou_bcd.

Verification (DIGITS=4, W=14)
REQ-027 rst=1 for one edge, then in_sel=00 -> ou_bcd=16'h0000, each seg digit 1000000, ou_busy=0, ou_tc=0.
REQ-028 in_p=14'b10011100001111 (9999), in_sel=11 one cycle -> ou_busy=1 for 14 cycles, then ou_bcd=16'h9999; next, in_sel=10, in_en=1 -> ou_tc=1 before the edge, ou_bcd=16'h0000 after it.
REQ-029 in_p=14'b01111001100001 (7777), load -> ou_bcd=16'h7777; in_sel=01, in_en=1 for 3 cycles -> 16'h7774; in_en=0 for 5 cycles -> stays 16'h7774.
REQ-030 ou_bcd=0000, in_sel=01, in_en=1 -> ou_tc=1, next ou_bcd=16'h9999; count up from 16'h0199 -> 16'h0200 in one cycle.
REQ-031 in_p=14'h3FFF (16383), load -> after 14 busy cycles ou_bcd=16'h9999 (saturated).
REQ-032 Load 1234 from count 16'h0042, rst=1 on the 5th busy cycle -> ou_busy=0, ou_bcd=16'h0000, and no later write of 1234.

Source files
------------

// File: rtl/bcd_updown_counter_n.sv
// bcd_updown_counter_n
//   Multi-digit BCD up/down counter with a binary parallel load. A load
//   runs a serial double-dabble conversion (one bit per cycle, W cycles).
//   The result is written to the count only when the conversion completes.
//   A load value above 10^DIGITS-1 saturates to all nines.
//
// Parameters
//   DIGITS : number of BCD digits held and displayed (1..8)
//   W      : width of the binary load value (>= 4)
//
// Ports
//   in_clk  : clock, rising edge active
//   rst     : synchronous active-high reset
//   in_sel  : 00 hold, 01 count down, 10 count up, 11 load
//   in_en   : count enable, qualifies 01/10 only
//   in_p    : unsigned binary load value
//   ou_bcd  : current count, digit 0 (units) in [3:0]
//   ou_seg  : active-low 7-segment patterns, digit i in [7i+6:7i], {g,f,e,d,c,b,a}
//   ou_busy : load conversion in progress
//   ou_tc   : the next counting edge wraps
module bcd_updown_counter_n #(
  parameter int DIGITS = 4,
  parameter int W      = 14
) (
  input  logic                  in_clk,
  input  logic                  rst,
  input  logic [1:0]            in_sel,
  input  logic                  in_en,
  input  logic [W-1:0]          in_p,
  output logic [4*DIGITS-1:0]   ou_bcd,
  output logic [7*DIGITS-1:0]   ou_seg,
  output logic                  ou_busy,
  output logic                  ou_tc
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(W);

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_DN   = 2'b01;
  localparam logic [1:0] SEL_UP   = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  localparam logic [BW-1:0] ALL_NINE = {DIGITS{4'h9}};
  localparam logic [BW-1:0] ALL_ZERO = '0;

  typedef enum logic {IDLE, CONV} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   bcd_q,   bcd_d;
  logic [W-1:0]    bin_q,   bin_d;
  logic [BW-1:0]   acc_q,   acc_d;
  logic            ovf_q,   ovf_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [BW:0]     step;

  // One double-dabble step: add 3 to every digit >= 5, then shift the
  // next binary bit in. The bit pushed out of the top digit means the
  // partial value has reached 10^DIGITS; since the partial value only
  // grows, that bit is kept as a sticky overflow flag.
  function automatic logic [BW:0] dd_step(input logic [BW-1:0] acc,
                                          input logic          bit_in);
    logic [BW-1:0] t;
    t = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (t[4*i +: 4] >= 4'd5) t[4*i +: 4] = t[4*i +: 4] + 4'd3;
    end
    return {t, bit_in};
  endfunction

  // Final load value: saturate to all nines on overflow.
  function automatic logic [BW-1:0] sat_bcd(input logic [BW-1:0] v,
                                            input logic          ovf);
    return ovf ? ALL_NINE : v;
  endfunction

  // BCD increment with carry rippling through all digits in one cycle.
  function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // BCD decrement with borrow rippling through all digits in one cycle.
  function automatic logic [BW-1:0] bcd_dec(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    logic          b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (r[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Active-low {g,f,e,d,c,b,a}; codes 10-15 are blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    step    = dd_step(acc_q, bin_q[W-1]);
    case (state_q)
      IDLE: begin
        case (in_sel)
          SEL_LOAD: begin
            bin_d   = in_p;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
            state_d = CONV;
          end
          SEL_UP:   if (in_en) bcd_d = bcd_inc(bcd_q);
          SEL_DN:   if (in_en) bcd_d = bcd_dec(bcd_q);
          default:  ;
        endcase
      end
      CONV: begin
        // in_sel/in_en are ignored; the count keeps its pre-load value
        // until the last step commits the converted result.
        bin_d = {bin_q[W-2:0], 1'b0};
        acc_d = step[BW-1:0];
        ovf_d = ovf_q | step[BW];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          bcd_d   = sat_bcd(step[BW-1:0], ovf_q | step[BW]);
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (rst) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      bin_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ou_bcd  = bcd_q;
  assign ou_busy = (state_q == CONV);
  assign ou_tc   = (state_q == IDLE) && in_en &&
                   (((in_sel == SEL_UP) && (bcd_q == ALL_NINE)) ||
                    ((in_sel == SEL_DN) && (bcd_q == ALL_ZERO)));

  always_comb begin
    ou_seg = '0;
    for (int i = 0; i < DIGITS; i++) begin
      ou_seg[7*i +: 7] = seg7(bcd_q[4*i +: 4]);
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
module tb_bcd_updown_counter_n;

  localparam int DIGITS = 4;
  localparam int W      = 14;
  localparam int MAXV   = 9999;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0]           sel;
  logic                 en;
  logic [W-1:0]         p;
  logic [4*DIGITS-1:0]  bcd;
  logic [7*DIGITS-1:0]  seg;
  logic                 busy;
  logic                 tc;

  always #5 clk = ~clk;

  bcd_updown_counter_n #(.DIGITS(DIGITS), .W(W)) dut (
    .in_clk  (clk),
    .rst     (rst),
    .in_sel  (sel),
    .in_en   (en),
    .in_p    (p),
    .ou_bcd  (bcd),
    .ou_seg  (seg),
    .ou_busy (busy),
    .ou_tc   (tc)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: decimal count plus remaining conversion cycles.
  int m_cnt  = 0;
  int m_rem  = 0;
  int m_pend = 0;

  typedef struct packed {
    logic [15:0] bcd;
    logic        busy;
    logic [27:0] seg;
  } exp_t;

  exp_t sb[$];

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          t;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [27:0] segs(input int v);
    logic [27:0] r;
    int          t;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[7*i +: 7] = seg_of(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic cyc(input logic r, input logic [1:0] s, input logic e, input int pv,
                     input string tag);
    exp_t x;
    logic exp_tc;
    int   pw;
    @(negedge clk);
    rst = r; sel = s; en = e; p = W'(pv);
    pw = pv & ((1 << W) - 1);
    #1;
    exp_tc = (m_rem == 0) && e &&
             (((s == 2'b10) && (m_cnt == MAXV)) || ((s == 2'b01) && (m_cnt == 0)));
    chk({tag, ".tc"}, 32'(tc), 32'(exp_tc));
    if (r) begin
      m_cnt = 0; m_rem = 0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) m_cnt = m_pend;
    end else begin
      case (s)
        2'b11: begin m_pend = (pw > MAXV) ? MAXV : pw; m_rem = W; end
        2'b10: if (e) m_cnt = (m_cnt + 1) % (MAXV + 1);
        2'b01: if (e) m_cnt = (m_cnt + MAXV) % (MAXV + 1);
        default: ;
      endcase
    end
    x.bcd  = to_bcd(m_cnt);
    x.busy = (m_rem != 0);
    x.seg  = segs(m_cnt);
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s.sb: got empty scoreboard expected entry", tag);
    end else begin
      x = sb.pop_front();
      chk({tag, ".bcd"},  32'(bcd),  32'(x.bcd));
      chk({tag, ".busy"}, 32'(busy), 32'(x.busy));
      chk({tag, ".seg"},  32'(seg),  32'(x.seg));
    end
  endtask

  task automatic hold(input int n, input logic [1:0] s, input logic e, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b0, s, e, 0, tag);
  endtask

  initial begin
    int pv;
    rst = 1'b1; sel = 2'b00; en = 1'b0; p = '0;
    @(posedge clk);

    cyc(1'b1, 2'b00, 1'b0, 0, "reset");
    hold(2, 2'b00, 1'b0, "idle");

    cyc(1'b0, 2'b11, 1'b0, 9999, "ld9999");
    hold(W, 2'b10, 1'b1, "conv9999");
    cyc(1'b0, 2'b10, 1'b1, 0, "wrap_up");

    cyc(1'b0, 2'b11, 1'b0, 7777, "ld7777");
    hold(W, 2'b01, 1'b1, "conv7777");
    hold(3, 2'b01, 1'b1, "down3");
    hold(5, 2'b01, 1'b0, "en_off");

    cyc(1'b1, 2'b01, 1'b1, 0, "rst_mid");
    cyc(1'b0, 2'b01, 1'b1, 0, "wrap_dn");

    cyc(1'b0, 2'b11, 1'b0, 199, "ld199");
    hold(W, 2'b00, 1'b0, "conv199");
    cyc(1'b0, 2'b10, 1'b1, 0, "ripple");

    cyc(1'b0, 2'b11, 1'b0, 16383, "ld16383");
    hold(W, 2'b00, 1'b0, "conv_sat");
    cyc(1'b0, 2'b11, 1'b0, 10000, "ld10000");
    hold(W, 2'b00, 1'b0, "conv_sat2");

    cyc(1'b0, 2'b11, 1'b0, 42, "ld42");
    hold(W, 2'b00, 1'b0, "conv42");
    cyc(1'b0, 2'b11, 1'b0, 1234, "ld1234");
    hold(4, 2'b00, 1'b0, "busy1234");
    cyc(1'b1, 2'b00, 1'b0, 0, "abort");
    hold(W + 4, 2'b00, 1'b0, "post_abort");

    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 4))
        0:       pv = 0;
        1:       pv = 9999;
        2:       pv = 10000;
        3:       pv = 16383;
        default: pv = int'($urandom_range(0, 16383));
      endcase
      cyc(($urandom_range(0, 59) == 0), 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), pv, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
